// File: rtl/calc_control_fsm.sv
// Keypad-driven calculator controller: decimal operand entry, operator latch,
// single-cycle add/sub/mul and a bit-serial restoring divider.
module calc_control_fsm #(
    parameter int WIDTH      = 9,
    parameter int MAX_DIGITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic [1:0]       op_sel,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             negative,
    output logic             error,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int DW = $clog2(WIDTH);
    localparam logic [WIDTH+3:0] MAX_VAL = {4'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH+3:0] TEN     = (WIDTH+4)'(10);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_OPA    = 3'd1,
        S_OPER   = 3'd2,
        S_OPB    = 3'd3,
        S_CALC   = 3'd4,
        S_RESULT = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t           cur_state;
    logic [CW-1:0]    digit_count;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;
    logic [DW-1:0]    div_cnt;

    logic             is_digit;
    logic             is_oper;
    logic             is_equals;
    logic             wipe;
    logic [1:0]       key_op;
    logic [WIDTH-1:0] key_digit;
    logic [CW-1:0]    first_count;
    logic [WIDTH-1:0] entry_reg;
    logic [WIDTH+3:0] appended;
    logic             append_ok;
    logic [WIDTH:0]   sum;
    logic [2*WIDTH-1:0] product;
    logic             mul_ovf;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    assign state = cur_state;

    // A leading zero on an empty register neither changes it nor uses up a digit slot.
    always_comb begin
        is_digit    = key_valid && (key_code <= 4'd9);
        is_oper     = key_valid && (key_code >= 4'd10) && (key_code <= 4'd13);
        is_equals   = key_valid && (key_code == 4'd14);
        wipe        = (key_valid && (key_code == 4'd15) && (cur_state != S_CALC))
                      || (state == 3'd7);
        key_op      = 2'(key_code - 4'd10);
        key_digit   = WIDTH'(key_code);
        first_count = (key_code == 4'd0) ? '0 : CW'(1);
        entry_reg   = (cur_state == S_OPB) ? operand_b : operand_a;
        appended    = {4'b0, entry_reg} * TEN + (WIDTH+4)'(key_code);
        append_ok   = (digit_count != CW'(MAX_DIGITS)) && (appended <= MAX_VAL)
                      && !((entry_reg == '0) && (key_code == 4'd0));
        sum         = {1'b0, operand_a} + {1'b0, operand_b};
        product     = (2*WIDTH)'(operand_a) * (2*WIDTH)'(operand_b);
        mul_ovf     = |product[2*WIDTH-1:WIDTH];
        rem_shift   = {div_rem, div_quo[WIDTH-1]};
        if (rem_shift >= {1'b0, operand_b}) begin
            rem_next = WIDTH'(rem_shift - {1'b0, operand_b});
            quo_next = {div_quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = rem_shift[WIDTH-1:0];
            quo_next = {div_quo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || wipe) begin
            cur_state   <= S_IDLE;
            operand_a   <= '0;
            operand_b   <= '0;
            op_sel      <= '0;
            result      <= '0;
            remainder   <= '0;
            negative    <= 1'b0;
            error       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            digit_count <= '0;
            div_rem     <= '0;
            div_quo     <= '0;
            div_cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (cur_state)
                S_IDLE: begin
                    if (is_digit) begin
                        operand_a   <= key_digit;
                        digit_count <= first_count;
                        cur_state   <= S_OPA;
                    end
                end
                S_OPA: begin
                    if (is_digit && append_ok) begin
                        operand_a   <= appended[WIDTH-1:0];
                        digit_count <= digit_count + CW'(1);
                    end else if (is_oper) begin
                        op_sel    <= key_op;
                        cur_state <= S_OPER;
                    end
                end
                S_OPER: begin
                    if (is_oper) begin
                        op_sel <= key_op;
                    end else if (is_digit) begin
                        operand_b   <= key_digit;
                        digit_count <= first_count;
                        cur_state   <= S_OPB;
                    end
                end
                S_OPB: begin
                    if (is_digit && append_ok) begin
                        operand_b   <= appended[WIDTH-1:0];
                        digit_count <= digit_count + CW'(1);
                    end else if (is_equals) begin
                        cur_state <= S_CALC;
                        busy      <= 1'b1;
                        div_rem   <= '0;
                        div_quo   <= operand_a;
                        div_cnt   <= '0;
                    end
                end
                S_CALC: begin
                    busy     <= 1'b0;
                    negative <= 1'b0;
                    case (op_sel)
                        2'd0: begin
                            cur_state <= sum[WIDTH] ? S_ERROR : S_RESULT;
                            error     <= sum[WIDTH];
                            done      <= !sum[WIDTH];
                            result    <= sum[WIDTH] ? '0 : sum[WIDTH-1:0];
                            remainder <= '0;
                        end
                        2'd1: begin
                            cur_state <= S_RESULT;
                            done      <= 1'b1;
                            remainder <= '0;
                            if (operand_a >= operand_b) begin
                                result <= operand_a - operand_b;
                            end else begin
                                result   <= operand_b - operand_a;
                                negative <= 1'b1;
                            end
                        end
                        2'd2: begin
                            cur_state <= mul_ovf ? S_ERROR : S_RESULT;
                            error     <= mul_ovf;
                            done      <= !mul_ovf;
                            result    <= mul_ovf ? '0 : product[WIDTH-1:0];
                            remainder <= '0;
                        end
                        default: begin
                            if (operand_b == '0) begin
                                cur_state <= S_ERROR;
                                error     <= 1'b1;
                                result    <= '0;
                                remainder <= '0;
                            end else begin
                                div_rem <= rem_next;
                                div_quo <= quo_next;
                                div_cnt <= div_cnt + DW'(1);
                                // The last step lands in RESULT directly, so done needs no extra cycle.
                                if (div_cnt == DW'(WIDTH - 1)) begin
                                    cur_state <= S_RESULT;
                                    done      <= 1'b1;
                                    result    <= quo_next;
                                    remainder <= rem_next;
                                end else begin
                                    busy <= 1'b1;
                                end
                            end
                        end
                    endcase
                end
                S_RESULT: begin
                    if (is_digit) begin
                        operand_a   <= key_digit;
                        digit_count <= first_count;
                        negative    <= 1'b0;
                        cur_state   <= S_OPA;
                    end else if (is_oper && !negative) begin
                        operand_a <= result;
                        operand_b <= '0;
                        op_sel    <= key_op;
                        cur_state <= S_OPER;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
